// File: rtl/dp_op_sched.sv
// dp_op_sched: round-robin scheduler feeding one shared registered logic datapath (q1 <= f ^ (q | g)).
// Optional macro RSP_CHECK_EN: carry the expected result to S3 and raise a sticky err on mismatch.
module dp_op_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_op,
    output logic [NREQ-1:0]   gnt,
    output logic              dp_d,
    output logic              dp_b,
    output logic              dp_f,
    output logic              dp_g,
    input  logic              dp_q1,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_data,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] ptr, gid, idx;
    logic           hit;
    logic [3:0]     gop;
    logic           s1_v, s2_v, s3_v;
    logic [IDW-1:0] s1_id, s2_id, s3_id;
    logic [3:0]     s1_op;
    logic [2:0]     s2_bfg;

    // First requester at or after the pointer wins; grants only while running, enabled and out of reset
    always_comb begin
        gnt = '0;
        gid = '0;
        idx = '0;
        hit = 1'b0;
        if (rst_n && state == RUN && en)
            for (int i = 0; i < NREQ; i++) begin
                idx = IDW'((int'(ptr) + i) % NREQ);
                if (!hit && req[idx]) begin
                    hit      = 1'b1;
                    gnt[idx] = 1'b1;
                    gid      = idx;
                end
            end
        gop = req_op[4*gid +: 4];
    end

    // Next state: enable always wins, otherwise running drains and an empty pipe goes idle
    always_comb begin
        state_nx = state;
        state_nx = en ? RUN :
                   (state == RUN) ? DRAIN :
                   (state == DRAIN && !(s1_v || s2_v || s3_v)) ? IDLE : state;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Pointer, operation pipeline S1..S3 and response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
        end else begin
            if (hit) ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            s1_v      <= hit;
            s1_id     <= gid;
            s1_op     <= gop;
            s2_v      <= s1_v;
            s2_id     <= s1_id;
            s2_bfg    <= s1_op[2:0];
            s3_v      <= s2_v;
            s3_id     <= s2_id;
            rsp_valid <= s3_v;
            if (s3_v) begin
                rsp_id   <= s3_id;
                rsp_data <= dp_q1;
            end
        end
    end

    assign dp_d = s1_v & s1_op[3];
    assign dp_b = s2_v & s2_bfg[2];
    assign dp_f = s2_v & s2_bfg[1];
    assign dp_g = s2_v & s2_bfg[0];
    assign busy = s1_v | s2_v | s3_v | rsp_valid;

`ifdef RSP_CHECK_EN
    logic s1_exp, s2_exp, s3_exp;

    // Expected result travels with the op; any S3 disagreement latches err until reset
    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else begin
            s1_exp <= gop[1] ^ (gop[3] | gop[0]);
            s2_exp <= s1_exp;
            s3_exp <= s2_exp;
            if (s3_v && dp_q1 != s3_exp) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: doc/dp_op_sched.md
Name: dp_op_sched

Overview:
- Round-robin scheduler that shares one registered logic datapath (d -> q; q1 <= f ^ (q | g)) among NREQ requesters.
- Accepts one operation per cycle and drives the datapath inputs in the correct cycle for each operation's pipeline stage.
- Captures the datapath result and returns it to the requester with an ID.
- Sits between the requesters and the datapath instance; owns all of the datapath's d/b/f/g inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scheduler enable; when low, no new grants are issued.
- req  input  NREQ  request per requester; level, held until granted.
- req_op  input  4*NREQ  operand per requester, slice k = {d,b,f,g}; must be valid while req[k]=1.
- gnt  output  NREQ  one-hot, combinational; operands are accepted at the clock edge ending the cycle in which gnt is high.
- dp_d  output  1  datapath d input.
- dp_b  output  1  datapath b input.
- dp_f  output  1  datapath f input.
- dp_g  output  1  datapath g input.
- dp_q1  input  1  datapath registered result.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_id  output  IDW  ID of the requester that owns the response.
- rsp_data  output  1  result bit.
- busy  output  1  high while any operation is in flight.
- err  output  1  sticky compare error (RSP_CHECK_EN only; otherwise tied 0).

Behaviour:
Reset (rst_n=0 at a clock edge):
- All pipeline valid bits, dp_* outputs, rsp_*, busy and err are cleared to 0.
- Round-robin pointer is set to 0; FSM goes to IDLE.
- Reset mid-operation discards all in-flight operations; no rsp_valid is produced for them.

FSM:
- IDLE -> RUN when en=1.
- RUN -> DRAIN when en=0.
- DRAIN -> IDLE when no stage is valid.
- DRAIN -> RUN when en=1 again; in-flight operations continue unaffected.

Grant:
- In RUN only: gnt[k]=1 for the first k with req[k]=1, searching from the pointer upward and wrapping at NREQ-1.
- No gnt is issued in IDLE or DRAIN.
- On a grant to k, the pointer becomes (k+1) mod NREQ; with no grant the pointer holds.
- At most one grant per cycle; simultaneous requests are resolved purely by the pointer.

Pipeline (grant in cycle t):
- t+1, stage S1: dp_d = op.d. The datapath captures q at the end of t+1.
- t+2, stage S2: dp_b = op.b, dp_f = op.f, dp_g = op.g. The datapath captures q1 at the end of t+2.
- t+3, stage S3: dp_q1 is valid; the scheduler registers dp_q1 and the ID at the end of t+3.
- t+4: rsp_valid=1 with rsp_id=k and rsp_data = op.f ^ (op.d | op.g).
- Grant-to-response latency is exactly 4 cycles. Throughput is 1 operation per cycle with back-to-back grants; different operations occupy different stages concurrently.

Bubbles and idle drive levels:
- A stage with no valid operation drives its dp_* outputs to 0.
- rsp_valid=0 for bubbles; rsp_id and rsp_data hold their previous values.

busy:
- busy = OR of the S1, S2, S3 and response valid bits.

Boundary cases:
- en dropped in the same cycle as a request: no grant.
- Operations in flight before en fell still complete.
- A request that is withdrawn before it is granted is simply dropped.

Optional Feature:
- Macro: RSP_CHECK_EN.
- Defined:
  - S3 also carries the expected result f ^ (d | g), computed at grant.
  - When dp_q1 differs from the expected value, err is set at the end of S3 and stays set until reset.
  - rsp_data still reflects dp_q1.
- Not defined:
  - No expected-value storage; err is constant 0.
  - rsp_data = registered dp_q1.

Test Plan:
- Reset then single op: en=1, req=0001, op0={d=1,b=0,f=0,g=0} -> gnt=0001 at t; dp_d=1 at t+1; dp_f=0, dp_g=0 at t+2; rsp_valid at t+4 with id=0, data=1.
- Round-robin fairness: req=1111 held for 8 cycles -> gnt order 0,1,2,3,0,1,2,3; responses in the same order, 4 cycles after each grant.
- Back-to-back pipelining: alternate op0={1,0,1,0} and op1={0,0,1,0} every cycle -> rsp_data sequence 0,1,0,1 with no bubbles; at each edge, dp_d and dp_f belong to different ops.
- Drain: two ops in flight, en=0 -> no new gnt; both responses still produced; busy falls one cycle after the last rsp_valid; FSM reaches IDLE.
- Reset mid-flight: rst_n=0 for one cycle with 3 ops in flight -> no rsp_valid afterwards; all dp_* = 0; pointer = 0 (next grant with req=1111 goes to requester 0).
- RSP_CHECK_EN: force dp_q1 inverted for one op -> err=1 one cycle after that op's S3 and stays 1 until reset; without the macro, err stays 0.
